// File: rtl/decoder_seq_pkg.sv
// Shared definitions for the sequenced line decoder: FSM state encoding and
// command mode constants.
package decoder_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic MODE_PULSE = 1'b0;
    localparam logic MODE_LEVEL = 1'b1;

endpackage

// File: rtl/decoder_seq_pulse_timer.sv
// Pulse-length counter: loads PULSE_LEN-1, counts down to zero and parks there.
module pulse_timer #(
    parameter int PULSE_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    output logic zero
);

    localparam int CNT_W = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PULSE_LEN - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/decoder_seq.sv
// Sequenced one-hot/one-cold decoder: pulse mode holds a line for PULSE_LEN
// cycles then strobes done; level mode holds a line until clr or a new command.
module decoder_seq
    import decoder_seq_pkg::*;
#(
    parameter int SEL_W     = 2,
    parameter int NOUT      = 2 ** SEL_W,
    parameter int PULSE_LEN = 4,
    parameter int ACT_HIGH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr,
    output logic [NOUT-1:0]  dec_out,
    output logic             busy,
    output logic             done
);

    if (SEL_W < 1 || SEL_W > 6) begin : g_bad_sel_w
        $fatal(1, "decoder_seq: SEL_W must be 1..6");
    end
    if (PULSE_LEN < 1) begin : g_bad_pulse_len
        $fatal(1, "decoder_seq: PULSE_LEN must be >= 1");
    end
    if (NOUT != 2 ** SEL_W) begin : g_bad_nout
        $fatal(1, "decoder_seq: NOUT must equal 2**SEL_W");
    end

    state_t          state;
    logic [NOUT-1:0] onehot;
    logic            accept;
    logic            load;
    logic            cnt_zero;

    assign in_ready = en && (state != ST_PULSE);
    assign accept   = in_valid && in_ready;
    assign load     = accept && !clr && (mode == MODE_PULSE);

    pulse_timer #(
        .PULSE_LEN(PULSE_LEN)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .clear (clr),
        .zero  (cnt_zero)
    );

    // Accept is impossible while in PULSE, so it can be tested ahead of expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            onehot <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clr) begin
                state  <= ST_IDLE;
                onehot <= '0;
                busy   <= 1'b0;
            end else if (accept) begin
                onehot <= {{(NOUT-1){1'b0}}, 1'b1} << sel;
                busy   <= 1'b1;
                state  <= (mode == MODE_LEVEL) ? ST_HOLD : ST_PULSE;
            end else if (state == ST_PULSE && cnt_zero) begin
                state  <= ST_IDLE;
                onehot <= '0;
                busy   <= 1'b0;
                done   <= 1'b1;
            end
        end
    end

    assign dec_out = (ACT_HIGH != 0) ? onehot : ~onehot;

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq: three configurations driven in one linear sequence.
module tb_decoder_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // A: SEL_W=2, PULSE_LEN=4, active high
    logic       a_en, a_mode, a_valid, a_clr, a_ready, a_busy, a_done;
    logic [1:0] a_sel;
    logic [3:0] a_dec;
    // B: SEL_W=3, PULSE_LEN=4, active low
    logic       b_en, b_mode, b_valid, b_clr, b_ready, b_busy, b_done;
    logic [2:0] b_sel;
    logic [7:0] b_dec;
    // C: SEL_W=2, PULSE_LEN=1, active high
    logic       c_en, c_mode, c_valid, c_clr, c_ready, c_busy, c_done;
    logic [1:0] c_sel;
    logic [3:0] c_dec;

    int n_checks = 0;
    int n_fail   = 0;

    decoder_seq #(.SEL_W(2), .PULSE_LEN(4), .ACT_HIGH(1)) u_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .sel(a_sel), .mode(a_mode),
        .in_valid(a_valid), .in_ready(a_ready), .clr(a_clr),
        .dec_out(a_dec), .busy(a_busy), .done(a_done));

    decoder_seq #(.SEL_W(3), .PULSE_LEN(4), .ACT_HIGH(0)) u_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .sel(b_sel), .mode(b_mode),
        .in_valid(b_valid), .in_ready(b_ready), .clr(b_clr),
        .dec_out(b_dec), .busy(b_busy), .done(b_done));

    decoder_seq #(.SEL_W(2), .PULSE_LEN(1), .ACT_HIGH(1)) u_c (
        .clk(clk), .rst_n(rst_n), .en(c_en), .sel(c_sel), .mode(c_mode),
        .in_valid(c_valid), .in_ready(c_ready), .clr(c_clr),
        .dec_out(c_dec), .busy(c_busy), .done(c_done));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_en = 1'b1; a_sel = '0; a_mode = 1'b0; a_valid = 1'b0; a_clr = 1'b0;
        b_en = 1'b1; b_sel = '0; b_mode = 1'b0; b_valid = 1'b0; b_clr = 1'b0;
        c_en = 1'b1; c_sel = '0; c_mode = 1'b0; c_valid = 1'b0; c_clr = 1'b0;

        // Reset state
        step(); step();
        chk("rst_a_dec", a_dec, 4'h0);
        chk("rst_a_busy", a_busy, 1'b0);
        chk("rst_a_done", a_done, 1'b0);
        chk("rst_b_dec", b_dec, 8'hFF);
        chk("rst_c_dec", c_dec, 4'h0);
        rst_n = 1'b1;
        step();
        chk("idle_a_ready", a_ready, 1'b1);

        // Pulse: sel=2 for exactly 4 cycles, then done for one cycle
        a_valid = 1'b1; a_sel = 2'd2; a_mode = 1'b0;
        step();
        a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pulse_dec_%0d", i), a_dec, 4'b0100);
            chk($sformatf("pulse_ready_%0d", i), a_ready, 1'b0);
            chk($sformatf("pulse_done_%0d", i), a_done, 1'b0);
            chk($sformatf("pulse_busy_%0d", i), a_busy, 1'b1);
            step();
        end
        chk("pulse_end_dec", a_dec, 4'h0);
        chk("pulse_end_done", a_done, 1'b1);
        chk("pulse_end_busy", a_busy, 1'b0);
        chk("pulse_end_ready", a_ready, 1'b1);
        step();
        chk("pulse_done_once", a_done, 1'b0);

        // Level: sel=3 held 10 cycles, then sel=0 replaces it with no gap
        a_valid = 1'b1; a_sel = 2'd3; a_mode = 1'b1;
        step();
        a_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold_dec_%0d", i), a_dec, 4'b1000);
            chk($sformatf("hold_done_%0d", i), a_done, 1'b0);
            if (i < 9) step();
        end
        a_valid = 1'b1; a_sel = 2'd0; a_mode = 1'b1;
        step();
        a_valid = 1'b0;
        chk("hold_swap_dec", a_dec, 4'b0001);
        chk("hold_swap_done", a_done, 1'b0);
        step();
        chk("hold_keep_dec", a_dec, 4'b0001);

        // HOLD -> PULSE on a mode=0 command
        a_valid = 1'b1; a_sel = 2'd1; a_mode = 1'b0;
        step();
        a_valid = 1'b0;
        chk("hold2pulse_dec", a_dec, 4'b0010);
        chk("hold2pulse_ready", a_ready, 1'b0);
        step(); step(); step();
        chk("hold2pulse_last", a_dec, 4'b0010);
        step();
        chk("hold2pulse_done", a_done, 1'b1);
        chk("hold2pulse_off", a_dec, 4'h0);

        // clr + in_valid together mid-pulse: clr wins, no done
        a_valid = 1'b1; a_sel = 2'd1; a_mode = 1'b0;
        step();
        a_valid = 1'b0;
        step();
        a_clr = 1'b1; a_valid = 1'b1; a_sel = 2'd3; a_mode = 1'b0;
        step();
        a_clr = 1'b0; a_valid = 1'b0;
        chk("clr_dec", a_dec, 4'h0);
        chk("clr_busy", a_busy, 1'b0);
        chk("clr_done", a_done, 1'b0);
        chk("clr_ready", a_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("clr_no_done_%0d", i), a_done, 1'b0);
        end

        // Async reset mid-pulse; first edge after release accepts
        a_valid = 1'b1; a_sel = 2'd3; a_mode = 1'b0;
        step();
        a_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dec", a_dec, 4'h0);
        chk("arst_busy", a_busy, 1'b0);
        step();
        a_valid = 1'b1; a_sel = 2'd0; a_mode = 1'b1;
        rst_n = 1'b1;
        step();
        a_valid = 1'b0;
        chk("post_rst_dec", a_dec, 4'b0001);
        chk("post_rst_busy", a_busy, 1'b1);
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        chk("post_rst_clr", a_dec, 4'h0);

        // en=0 blocks accepts for every sel
        a_en = 1'b0;
        for (int s = 0; s < 4; s++) begin
            a_valid = 1'b1; a_sel = 2'(s); a_mode = 1'b0;
            step();
            chk($sformatf("en0_dec_%0d", s), a_dec, 4'h0);
            chk($sformatf("en0_ready_%0d", s), a_ready, 1'b0);
            chk($sformatf("en0_busy_%0d", s), a_busy, 1'b0);
        end
        a_valid = 1'b0;

        // en falling during a pulse does not disturb it
        a_en = 1'b1; a_valid = 1'b1; a_sel = 2'd2; a_mode = 1'b0;
        step();
        a_valid = 1'b0; a_en = 1'b0;
        step(); step(); step();
        chk("en_fall_dec", a_dec, 4'b0100);
        step();
        chk("en_fall_done", a_done, 1'b1);
        chk("en_fall_off", a_dec, 4'h0);
        a_en = 1'b1;

        // Active-low, SEL_W=3: sel=5 -> 11011111 for 4 cycles, then FF
        b_valid = 1'b1; b_sel = 3'd5; b_mode = 1'b0;
        step();
        b_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b_pulse_%0d", i), b_dec, 8'hDF);
            step();
        end
        chk("b_end_dec", b_dec, 8'hFF);
        chk("b_end_done", b_done, 1'b1);

        // PULSE_LEN=1: one active cycle, done on the next
        c_valid = 1'b1; c_sel = 2'd1; c_mode = 1'b0;
        step();
        c_valid = 1'b0;
        chk("c_dec", c_dec, 4'b0010);
        chk("c_done0", c_done, 1'b0);
        step();
        chk("c_off", c_dec, 4'h0);
        chk("c_done1", c_done, 1'b1);
        step();
        chk("c_done2", c_done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
- REQ-001 SHALL have parameter SEL_W, default 2: select width; legal 1..6.
- REQ-002 SHALL have parameter NOUT, fixed at 2**SEL_W: number of decoded lines.
- REQ-003 SHALL have parameter PULSE_LEN, default 4: cycles a pulse-mode line stays active; legal >=1.
- REQ-004 SHALL have parameter ACT_HIGH, default 1: 1 = active line is 1; 0 = active line is 0 and inactive lines are 1.
- REQ-005 SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
- REQ-006 SHALL provide the following ports (name, direction, width, meaning):
  - clk  in  1  rising-edge clock
  - rst_n  in  1  asynchronous active-low reset
  - en  in  1  block enable; 0 blocks acceptance of new commands
  - sel  in  SEL_W  line index to assert
  - mode  in  1  0 = PULSE, 1 = LEVEL (sampled with sel)
  - in_valid  in  1  command present
  - in_ready  out  1  block can accept a command
  - clr  in  1  synchronous clear/abort
  - dec_out  out  NOUT  registered one-hot (or one-cold) decode
  - busy  out  1  a line is currently active
  - done  out  1  one-cycle strobe at normal pulse completion

Function
- REQ-007 SHALL accept a command on a rising edge where in_valid=1 and in_ready=1.
- REQ-008 SHALL drive in_ready = en AND (state != PULSE), combinationally from state.
- REQ-009 SHALL implement FSM states IDLE, PULSE and HOLD.
- REQ-010 SHALL transition: IDLE -> PULSE on accept with mode=0; IDLE or HOLD -> HOLD on accept with mode=1; HOLD -> PULSE on accept with mode=0.
- REQ-011 SHALL make dec_out reflect an accepted sel on the edge of acceptance, i.e. visible in the following cycle (latency 1); exactly bit sel active, all other bits inactive.
- REQ-012 SHALL, on entering PULSE, load a counter with PULSE_LEN-1 and decrement it each cycle; when the counter is 0, the next edge returns to IDLE, deactivates all lines and asserts done for exactly one cycle.
- REQ-013 SHALL therefore hold a PULSE-mode line active for exactly PULSE_LEN cycles; PULSE_LEN=1 gives a single-cycle line followed by done in the next cycle.
- REQ-014 SHALL, in HOLD, keep the line active indefinitely until clr or a new accept; a new accept replaces the active line on the same edge with no inactive gap.
- REQ-015 SHALL give clr priority over accept on the same edge: go to IDLE, all lines inactive, counter 0, no done strobe; this also aborts a PULSE in progress.
- REQ-016 SHALL, when en falls, stop further accepts only; an active PULSE or HOLD continues unaffected.
- REQ-017 SHALL drive busy = (state != IDLE), registered.
- REQ-018 SHALL size the counter as $clog2(PULSE_LEN+1) bits; it never wraps.
- REQ-019 SHALL apply output polarity only at the final output stage, as dec_out = ACT_HIGH ? onehot : ~onehot.

Reset
- REQ-020 SHALL, while rst_n=0, asynchronously force state=IDLE, counter=0, busy=0, done=0, and all dec_out lines inactive (all 0 if ACT_HIGH=1, all 1 if ACT_HIGH=0).
- REQ-021 SHALL discard any in-progress pulse when reset is asserted mid-operation; it does not resume after release.
- REQ-022 SHALL make the first accept possible on the first rising edge after rst_n deasserts.

Structure
- REQ-023 SHALL define the state encoding (IDLE/PULSE/HOLD) and the mode constants (MODE_PULSE=0, MODE_LEVEL=1) in shared package decoder_seq_pkg.
- REQ-024 SHALL place the load/decrement/zero-detect counter in sub-module pulse_timer, parameterised by PULSE_LEN.
- REQ-025 SHALL check parameter legality at elaboration (SEL_W 1..6, PULSE_LEN>=1) and fail elaboration on illegal values.

Verification
- REQ-026 Bench SHALL cover: SEL_W=2, PULSE_LEN=4, accept sel=2 mode=0 -> dec_out=4'b0100 for exactly 4 cycles, then 0000 with done=1 for 1 cycle; in_ready=0 throughout.
- REQ-027 Bench SHALL cover: mode=1, sel=3 then, 10 cycles later, sel=0 mode=1 -> 1000 held, then 0001 on the next cycle with no 0000 gap; done never asserted.
- REQ-028 Bench SHALL cover: clr and in_valid asserted together during PULSE -> next cycle dec_out=0000, state IDLE, done=0.
- REQ-029 Bench SHALL cover: ACT_HIGH=0, SEL_W=3, sel=5 mode=0 -> dec_out=8'b11011111, returning to 8'hFF after PULSE_LEN cycles.
- REQ-030 Bench SHALL cover: rst_n pulled low mid-pulse -> dec_out inactive immediately (asynchronously), busy=0; after release, one in_valid is accepted on the first edge.
- REQ-031 Bench SHALL cover: en=0 with in_valid=1 for all sel values -> no accept and dec_out inactive; PULSE_LEN=1 -> line active for 1 cycle, done on the next cycle.
